seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
- Clocked successor to the combinational calculator display path. It latches a signed BCD value from either the operand-entry path or the ALU result, then time-multiplexes it onto a common-anode 7-segment bank.
- Parametrised in digit count, anode count, refresh rate and output polarity.
- Adds leading-zero blanking, an invalid-digit indication, a global blank and a frame-done strobe.
- Sits between the ALU/entry logic and the board's segment and anode pins.

Parameters:
- NUM_DIGITS, 3: magnitude BCD digits. The display uses NUM_DIGITS+1 positions; the leftmost is the sign. Legal range 1..7.
- NUM_AN, 8: physical anodes driven. Must be ≥ NUM_DIGITS+1.
- REFRESH_DIV, 100000: clock cycles per scan position. Must be ≥ 2.
- ACTIVE_LOW, 1: when 1, seg and an are inverted at the pins (segment on = 0, anode on = 0).
- BLANK_LZ, 1: when 1, leading-zero blanking is enabled.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- in_bcd  in  4*NUM_DIGITS  entry-path BCD, digit 0 = LSD at [3:0]
- in_sign  in  1  entry-path sign, 1 = negative
- alu_bcd  in  4*NUM_DIGITS  ALU BCD result, same packing as in_bcd
- alu_sign  in  1  ALU sign
- src_sel  in  1  0 = entry path, 1 = ALU
- load  in  1  single-cycle strobe; captures the selected source
- blank  in  1  forces all anodes off while high
- seg  out  7  {a,b,c,d,e,f,g}, a = bit 6
- an  out  NUM_AN  anode enables, an[0] = rightmost digit
- scan_pos  out  ceil(log2(NUM_DIGITS+1))  current position index
- frame_done  out  1  one-cycle pulse when the scan wraps
- bcd_err  out  1  held high while the held value contains any nibble > 9

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - Held value = 0, held sign = 0, divider = 0, scan_pos = 0.
  - seg = blank, all an = off, frame_done = 0, bcd_err = 0.
  - Polarity is applied after reset values, so ACTIVE_LOW = 1 gives seg = 7'h7F and an = all 1s.
  - Reset mid-scan or mid-load discards all state; the load is lost.
- Capture: on a clk edge with load = 1, the held value and sign take the src_sel-selected source. Otherwise the held value is unchanged. The display never follows live inputs.
- Divider: counts 0..REFRESH_DIV-1. A tick occurs when the divider equals REFRESH_DIV-1; the divider then wraps to 0.
- Scan position:
  - On tick, scan_pos increments.
  - From NUM_DIGITS it wraps to 0, and frame_done pulses high for exactly that one cycle.
- Output timing:
  - seg and an are registered and reflect the new scan_pos in the same cycle scan_pos updates (one cycle after the tick edge).
  - A load takes effect on seg no later than the next output register update.
- Anode mapping:
  - Position p (0..NUM_DIGITS) drives an[p] only.
  - an[NUM_AN-1 : NUM_DIGITS+1] are always off.
  - blank = 1 turns all an off; seg is still computed.
- Digit positions p < NUM_DIGITS, decoded (active-high) as:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - A nibble > 9 shows E = 1001111.
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit p is blank (0000000) if it and every higher digit are 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - An invalid nibble counts as nonzero.
- Sign position (p = NUM_DIGITS):
  - Held sign 1 shows minus = 0000001; sign 0 shows blank.
  - Negative zero still shows the minus.
- bcd_err: combinational on the held value. Registered or not is implementer's choice, but it must settle within 1 cycle after a load.
- Simultaneous load and tick: both act. The new value is displayed at the new position.

Test Plan:
- Reset: REFRESH_DIV = 4, ACTIVE_LOW = 1, hold rst_n low for 3 cycles -> seg = 7'h7F, an = 8'hFF, scan_pos = 0, frame_done = 0.
- Entry path: src_sel = 0, in_bcd = 12'h047, in_sign = 1, load pulse; then scan a full frame.
  - pos0: an = 8'hFE, seg = ~7'b1110000.
  - pos1: seg = ~7'b0110011.
  - pos2: blank, seg = 7'h7F.
  - pos3: minus, seg = 7'b1111110.
  - frame_done pulses once every 16 cycles.
- ALU path with value 0: src_sel = 1, alu_bcd = 12'h000, alu_sign = 0, load -> pos0 shows "0" (~7'b1111110); pos1, pos2 and pos3 are blank. Changing in_bcd afterwards without load leaves the display unchanged.
- Invalid digit: alu_bcd = 12'h0A3, load -> bcd_err = 1; pos1 shows E (~7'b1001111); pos2 blank; pos0 shows 3.
- Blank, and load coincident with tick:
  - blank = 1 for one frame -> an = 8'hFF throughout, while scan_pos keeps advancing.
  - load asserted on a tick edge -> new value appears at the new position in the next output update.
- Reset mid-frame: rst_n low at scan_pos = 2 -> scan_pos = 0 and display blank next cycle. A load asserted in the same cycle as the reset is ignored.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Latches a signed BCD value and time-multiplexes it onto a
//               common-anode 7-segment bank with sign, LZ blanking and error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 3,
    parameter int NUM_AN      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [4*NUM_DIGITS-1:0]           in_bcd,
    input  logic                              in_sign,
    input  logic [4*NUM_DIGITS-1:0]           alu_bcd,
    input  logic                              alu_sign,
    input  logic                              src_sel,
    input  logic                              load,
    input  logic                              blank,
    output logic [6:0]                        seg,
    output logic [NUM_AN-1:0]                 an,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   scan_pos,
    output logic                              frame_done,
    output logic                              bcd_err
);

    localparam int                   C_POS_W    = $clog2(NUM_DIGITS + 1);
    localparam int                   C_DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [C_DIV_W-1:0]   C_DIV_LAST = C_DIV_W'(REFRESH_DIV - 1);
    localparam logic [C_POS_W-1:0]   C_POS_LAST = C_POS_W'(NUM_DIGITS);
    // XOR masks: applying them to an active-high pattern yields the pin level
    localparam logic [6:0]           C_SEG_OFF  = {7{(ACTIVE_LOW != 0)}};
    localparam logic [NUM_AN-1:0]    C_AN_OFF   = {NUM_AN{(ACTIVE_LOW != 0)}};
    localparam logic [6:0]           C_SEG_MINUS = 7'b0000001;

    logic [4*NUM_DIGITS-1:0] held_val_q, held_val_d;
    logic                    held_sign_q, held_sign_d;
    logic [C_DIV_W-1:0]      div_q, div_d;
    logic [C_POS_W-1:0]      pos_q, pos_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_AN-1:0]       an_q, an_d;
    logic                    frame_done_q, frame_done_d;
    logic                    bcd_err_q, bcd_err_d;

    logic                    w_tick;
    logic [6:0]              w_dig_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_dig_err;
    logic [6:0]              w_seg_act;
    logic [NUM_AN-1:0]       w_an_act;

    function automatic logic [6:0] decode_digit(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
            default: pat = 7'b1001111;
        endcase
        return pat;
    endfunction

    // Capture, refresh divider and scan position
    always_comb begin
        w_tick       = (div_q == C_DIV_LAST);
        held_val_d   = held_val_q;
        held_sign_d  = held_sign_q;
        if (load) begin
            held_val_d  = src_sel ? alu_bcd  : in_bcd;
            held_sign_d = src_sel ? alu_sign : in_sign;
        end
        div_d        = w_tick ? '0 : div_q + C_DIV_W'(1);
        pos_d        = pos_q;
        frame_done_d = 1'b0;
        if (w_tick) begin
            if (pos_q == C_POS_LAST) begin
                pos_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                pos_d = pos_q + C_POS_W'(1);
            end
        end
    end

    // Per-digit pattern; a digit blanks when it and everything above it is zero
    generate
        for (genvar p = 0; p < NUM_DIGITS; p++) begin : g_digit
            logic [3:0] w_nib;
            logic       w_nz_upper;
            assign w_nib        = held_val_d[4*p +: 4];
            assign w_nz_upper   = |held_val_d[4*NUM_DIGITS-1:4*p];
            assign w_dig_err[p] = (w_nib > 4'd9);
            assign w_dig_seg[p] = ((BLANK_LZ != 0) && (p != 0) && !w_nz_upper)
                                  ? 7'b0000000 : decode_digit(w_nib);
        end
    endgenerate

    // Outputs are computed from next-state values so they track scan_pos and loads
    always_comb begin
        w_seg_act = 7'b0000000;
        w_an_act  = '0;
        if (pos_d == C_POS_LAST) begin
            w_seg_act = held_sign_d ? C_SEG_MINUS : 7'b0000000;
        end
        for (int p = 0; p < NUM_DIGITS; p++) begin
            if (pos_d == C_POS_W'(p)) begin
                w_seg_act = w_dig_seg[p];
            end
        end
        for (int p = 0; p <= NUM_DIGITS; p++) begin
            if (!blank && (pos_d == C_POS_W'(p))) begin
                w_an_act[p] = 1'b1;
            end
        end
        seg_d     = w_seg_act ^ C_SEG_OFF;
        an_d      = w_an_act ^ C_AN_OFF;
        bcd_err_d = |w_dig_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_val_q   <= '0;
            held_sign_q  <= 1'b0;
            div_q        <= '0;
            pos_q        <= '0;
            seg_q        <= C_SEG_OFF;
            an_q         <= C_AN_OFF;
            frame_done_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            held_val_q   <= held_val_d;
            held_sign_q  <= held_sign_d;
            div_q        <= div_d;
            pos_q        <= pos_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign scan_pos   = pos_q;
    assign frame_done = frame_done_q;
    assign bcd_err    = bcd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
// ============================================================================
// Module      : tb_seven_seg_scan_driver
// Description : Directed plus random stimulus against a time-index display model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_driver;

    localparam int ND   = 3;
    localparam int NA   = 8;
    localparam int RDIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [11:0]   in_bcd;
    logic          in_sign;
    logic [11:0]   alu_bcd;
    logic          alu_sign;
    logic          src_sel;
    logic          load;
    logic          blank;
    logic [6:0]    seg;
    logic [NA-1:0] an;
    logic [1:0]    scan_pos;
    logic          frame_done;
    logic          bcd_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: k = clock edges since the last reset edge; display is a pure function of k
    int          k = 0;
    logic [11:0] m_val = '0;
    logic        m_sign = 1'b0;
    logic        m_blank = 1'b0;
    bit          m_in_reset = 1'b1;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS (ND),
        .NUM_AN     (NA),
        .REFRESH_DIV(RDIV),
        .ACTIVE_LOW (1),
        .BLANK_LZ   (1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bcd    (in_bcd),
        .in_sign   (in_sign),
        .alu_bcd   (alu_bcd),
        .alu_sign  (alu_sign),
        .src_sel   (src_sel),
        .load      (load),
        .blank     (blank),
        .seg       (seg),
        .an        (an),
        .scan_pos  (scan_pos),
        .frame_done(frame_done),
        .bcd_err   (bcd_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    function automatic logic [6:0] digit_pattern(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b1001111;
        endcase
    endfunction

    // Active-high pattern expected at display position pos
    function automatic logic [6:0] exp_position(input int pos);
        int v;
        int d;
        v = int'(m_val);
        if (pos == ND) return m_sign ? 7'b0000001 : 7'b0000000;
        d = (v >> (4 * pos)) & 15;
        if (pos > 0 && (v >> (4 * pos)) == 0) return 7'b0000000;
        return digit_pattern(d);
    endfunction

    task automatic compare_all();
        logic [6:0]    e_seg;
        logic [NA-1:0] e_an;
        int            pos;
        bit            e_err;
        if (m_in_reset) begin
            check_eq("seg", 32'(seg), 32'h7F);
            check_eq("an", 32'(an), 32'hFF);
            check_eq("scan_pos", 32'(scan_pos), 32'd0);
            check_eq("frame_done", 32'(frame_done), 32'd0);
            check_eq("bcd_err", 32'(bcd_err), 32'd0);
        end else begin
            pos   = (k / RDIV) % (ND + 1);
            e_seg = ~exp_position(pos);
            e_an  = '1;
            if (!m_blank) e_an[pos] = 1'b0;
            e_err = 1'b0;
            for (int i = 0; i < ND; i++) begin
                if (((int'(m_val) >> (4 * i)) & 15) > 9) e_err = 1'b1;
            end
            check_eq("seg", 32'(seg), 32'(e_seg));
            check_eq("an", 32'(an), 32'(e_an));
            check_eq("scan_pos", 32'(scan_pos), 32'(pos));
            check_eq("frame_done", 32'(frame_done), 32'((k % (RDIV * (ND + 1))) == 0));
            check_eq("bcd_err", 32'(bcd_err), 32'(e_err));
        end
    endtask

    task automatic cycle(input logic r, input logic ld, input logic sel, input logic blk);
        rst_n   = r;
        load    = ld;
        src_sel = sel;
        blank   = blk;
        @(posedge clk);
        if (!r) begin
            k          = 0;
            m_val      = '0;
            m_sign     = 1'b0;
            m_in_reset = 1'b1;
        end else begin
            k++;
            m_in_reset = 1'b0;
            m_blank    = blk;
            if (ld) begin
                m_val  = sel ? alu_bcd  : in_bcd;
                m_sign = sel ? alu_sign : in_sign;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] v;
        int          r;
        for (int i = 0; i < ND; i++) begin
            r = $urandom_range(0, 3);
            v[4*i +: 4] = (r == 0) ? 4'd0 : (r == 1) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; load = 1'b0; src_sel = 1'b0; blank = 1'b0;
        in_bcd = '0; in_sign = 1'b0; alu_bcd = '0; alu_sign = 1'b0;
        @(negedge clk);

        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_seg_lit", 32'(seg), 32'h7F);
        check_eq("rst_an_lit", 32'(an), 32'hFF);

        // Entry path -47
        in_bcd = 12'h047; in_sign = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("p0_an_lit", 32'(an), 32'hFE);
        check_eq("p0_seg_lit", 32'(seg), 32'h0F);
        repeat (16) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // ALU zero, then live entry changes must not show
        alu_bcd = 12'h000; alu_sign = 1'b0;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (16) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        in_bcd = 12'h999; in_sign = 1'b1;
        repeat (16) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Invalid nibble
        alu_bcd = 12'h0A3;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("err_lit", 32'(bcd_err), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (scan_pos == 2'd1) check_eq("E_pos1_lit", 32'(seg), 32'h30);
        end

        // Global blank for a frame
        repeat (16) cycle(1'b1, 1'b0, 1'b0, 1'b1);

        // Load coincident with a tick edge
        for (int i = 0; i < RDIV && (k % RDIV) != RDIV - 1; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        alu_bcd = 12'h512; alu_sign = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame with a coincident load
        for (int i = 0; i < 16 && ((k / RDIV) % (ND + 1)) != 2; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        in_bcd = 12'h888; in_sign = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("midrst_pos_lit", 32'(scan_pos), 32'd0);
        check_eq("midrst_seg_lit", 32'(seg), 32'h7F);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_bcd   = rand_bcd();
            alu_bcd  = rand_bcd();
            in_sign  = 1'($urandom_range(0, 1));
            alu_sign = 1'($urandom_range(0, 1));
            cycle(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
